// File: rtl/vector_sequencer_pkg.sv
// Shared types for the vector display-list sequencer: FSM states, segment
// layout and the coordinate type.
package vector_sequencer_pkg;

    localparam int CNT_W = 16;

    typedef logic [7:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } segment_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_DATA  = 3'd2,
        ST_MOVE       = 3'd3,
        ST_DRAW_START = 3'd4,
        ST_DRAW_WAIT  = 3'd5,
        ST_NEXT       = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

endpackage

// File: rtl/vector_sequencer_seq_counter.sv
// Loadable down-counter that parks at zero; o_zero flags the terminal count.
module seq_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Walks a display list of line segments, blanking the beam to settle before
// any segment that does not start where the previous one ended.
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DRAW_TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [7:0]  list_len,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic [7:0]  ld_x0,
    output logic [7:0]  ld_y0,
    output logic [7:0]  ld_x1,
    output logic [7:0]  ld_y1,
    output logic        ld_start,
    input  logic        ld_done,
    output logic        beam_on,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        timeout_err,
    output state_t      dbg_state
);

    // MOVE lasts SETTLE_CYCLES+1 cycles; DRAW_WAIT lasts at most DRAW_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = (DRAW_TIMEOUT > 0) ? CNT_W'(DRAW_TIMEOUT - 1) : '0;

    state_t         r_state;
    state_t         w_next_state;
    logic [7:0]     r_idx;
    logic [7:0]     r_len;
    logic [15:0]    r_prev;
    segment_t       r_seg;
    logic           r_timeout_err;

    logic           w_settle_zero;
    logic           w_timeout_zero;
    logic           w_timeout;
    logic           w_last;
    logic           w_discontig;

    seq_counter #(.WIDTH(CNT_W)) u_settle (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (r_state == ST_WAIT_DATA),
        .i_en       (r_state == ST_MOVE),
        .i_load_val (SETTLE_LOAD),
        .o_zero     (w_settle_zero)
    );

    seq_counter #(.WIDTH(CNT_W)) u_timeout (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (r_state == ST_DRAW_START),
        .i_en       (r_state == ST_DRAW_WAIT),
        .i_load_val (TIMEOUT_LOAD),
        .o_zero     (w_timeout_zero)
    );

    // ld_done wins over an expiring timeout in the same cycle.
    assign w_timeout   = (r_state == ST_DRAW_WAIT) && !ld_done && w_timeout_zero;
    assign w_last      = (({1'b0, r_idx} + 9'd1) == {1'b0, r_len});
    assign w_discontig = (r_idx == 8'd0) || (mem_data[31:16] != r_prev);

    always_comb begin
        w_next_state = r_state;
        mem_rd       = 1'b0;
        mem_addr     = 8'd0;
        ld_start     = 1'b0;
        beam_on      = 1'b0;
        frame_busy   = 1'b1;
        frame_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                frame_busy = 1'b0;
                if (frame_start) begin
                    w_next_state = (list_len == 8'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd       = 1'b1;
                mem_addr     = r_idx;
                w_next_state = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                w_next_state = w_discontig ? ST_MOVE : ST_DRAW_START;
            end
            ST_MOVE: begin
                if (w_settle_zero) begin
                    w_next_state = ST_DRAW_START;
                end
            end
            ST_DRAW_START: begin
                ld_start     = 1'b1;
                w_next_state = ST_DRAW_WAIT;
            end
            ST_DRAW_WAIT: begin
                beam_on = 1'b1;
                if (ld_done || w_timeout_zero) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_next_state = w_last ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                frame_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 8'd0;
            r_len         <= 8'd0;
            r_prev        <= 16'd0;
            r_seg         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && frame_start) begin
                r_len <= list_len;
                r_idx <= 8'd0;
            end
            if (r_state == ST_WAIT_DATA) begin
                r_seg <= mem_data;
            end
            if (r_state == ST_NEXT) begin
                r_prev <= {r_seg.x1, r_seg.y1};
                r_idx  <= r_idx + 8'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ld_x0       = r_seg.x0;
    assign ld_y0       = r_seg.y0;
    assign ld_x1       = r_seg.x1;
    assign ld_y1       = r_seg.y1;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule
